stall_ctrl: RTL and testbench

STALL_CTRL -- requirements
Module: stall_ctrl

---
 rtl/stall_pkg.sv | 37 +++
 rtl/md_busy_cnt.sv | 33 +++
 rtl/stall_ctrl.sv | 131 +++++++++++++
 tb/tb_stall_ctrl.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stall_pkg.sv
// stall_pkg: shared constants and types for the stall controller.
//   TUSE_*      : cycles until a D-stage operand is consumed
//   TNEW_*      : cycles until a produced result can be forwarded
//   MULT_CYCLES : busy cycles of the multiply unit after issue
//   DIV_CYCLES  : busy cycles of the divide unit after issue
//   stage_t     : one pipeline entry (dest, tnew, md start, div qualifier)
// The optional multiply/divide tracking is enabled by STALL_CTRL_MD_EN.
package stall_pkg;

    localparam logic [1:0] TUSE_0 = 2'd0;
    localparam logic [1:0] TUSE_1 = 2'd1;
    localparam logic [1:0] TUSE_2 = 2'd2;

    localparam logic [1:0] TNEW_0 = 2'd0;
    localparam logic [1:0] TNEW_1 = 2'd1;
    localparam logic [1:0] TNEW_2 = 2'd2;

    localparam logic [3:0] MULT_CYCLES = 4'd5;
    localparam logic [3:0] DIV_CYCLES  = 4'd10;

    typedef struct packed {
        logic [4:0] dest;
        logic [1:0] tnew;
        logic       md;
        logic       div;
    } stage_t;

    localparam stage_t BUBBLE = '0;

    // An entry blocks an operand when it writes that register (not $0)
    // and its result arrives later than the operand is needed.
    function automatic logic hazard(input stage_t s, input logic [4:0] rnum,
                                    input logic has_use, input logic [1:0] tuse);
        return has_use && (s.dest != 5'd0) && (s.dest == rnum) && (s.tnew > tuse);
    endfunction

endpackage

// File: rtl/md_busy_cnt.sv
// md_busy_cnt: occupancy counter of the multiply/divide unit.
//   clk, reset : clock, asynchronous active-low reset
//   start      : E-stage entry is a mult/div issue
//   div        : qualifies start as a divide
//   busy       : unit occupied (counting, or an issue sitting in E)
// Only built when STALL_CTRL_MD_EN is defined.
module md_busy_cnt
    import stall_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic div,
    output logic busy
);

    logic [3:0] count;

    // A new issue reloads the counter even if an older one is still
    // draining, so load has priority over decrement.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= 4'd0;
        end else if (start) begin
            count <= div ? DIV_CYCLES : MULT_CYCLES;
        end else if (count != 4'd0) begin
            count <= count - 4'd1;
        end
    end

    assign busy = (count != 4'd0) || start;

endmodule

// File: rtl/stall_ctrl.sv
// stall_ctrl: Tuse/Tnew hazard detection and pipeline bookkeeping for a
// five-stage MIPS-style core.
//   clk, reset           : clock, asynchronous active-low reset
//   d_j..d_jal           : D-stage instruction class flags
//   d_rs, d_rt, d_rd     : D-stage register fields (d_rd = 31 for jal)
//   d_md_start/div/use   : D-stage multiply/divide information
//   stall                : freeze PC/D, insert bubble into E (combinational)
//   e_dest/m_dest        : destination of E/M entries (0 = none)
//   e_tnew/m_tnew        : remaining cycles until forwardable
//   md_busy              : multiply/divide unit occupied
// Define STALL_CTRL_MD_EN to build the multiply/divide busy tracking;
// without it the d_md_* inputs are ignored and md_busy is 0.
module stall_ctrl
    import stall_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       d_j,
    input  logic       d_r,
    input  logic       d_i,
    input  logic       d_ld,
    input  logic       d_st,
    input  logic       d_jal,
    input  logic [4:0] d_rs,
    input  logic [4:0] d_rt,
    input  logic [4:0] d_rd,
    input  logic       d_md_start,
    input  logic       d_md_div,
    input  logic       d_md_use,
    output logic       stall,
    output logic [4:0] e_dest,
    output logic [4:0] m_dest,
    output logic [1:0] e_tnew,
    output logic [1:0] m_tnew,
    output logic       md_busy
);

    stage_t     e_q;
    stage_t     m_q;
    stage_t     d_entry;
    logic       rs_use;
    logic       rt_use;
    logic [1:0] rs_tuse;
    logic [1:0] rt_tuse;
    logic       data_stall;
    logic       md_stall;

    // Operand demand of the D-stage instruction. Branch/jump operands are
    // needed immediately; a store needs its data register one stage later.
    always_comb begin
        rs_use  = d_j || d_r || d_i || d_ld || d_st;
        rt_use  = d_j || d_r || d_st;
        rs_tuse = d_j ? TUSE_0 : TUSE_1;
        if (d_j) begin
            rt_tuse = TUSE_0;
        end else if (d_r) begin
            rt_tuse = TUSE_1;
        end else begin
            rt_tuse = TUSE_2;
        end
    end

    // What the D-stage instruction will carry into E.
    always_comb begin
        d_entry = BUBBLE;
        if (d_r || d_jal) begin
            d_entry.dest = d_rd;
        end else if (d_i || d_ld) begin
            d_entry.dest = d_rt;
        end
        if (d_ld) begin
            d_entry.tnew = TNEW_2;
        end else if (d_r || d_i) begin
            d_entry.tnew = TNEW_1;
        end else begin
            d_entry.tnew = TNEW_0;
        end
`ifdef STALL_CTRL_MD_EN
        d_entry.md  = d_md_start;
        d_entry.div = d_md_div;
`endif
    end

    assign data_stall = hazard(e_q, d_rs, rs_use, rs_tuse) ||
                        hazard(e_q, d_rt, rt_use, rt_tuse) ||
                        hazard(m_q, d_rs, rs_use, rs_tuse) ||
                        hazard(m_q, d_rt, rt_use, rt_tuse);

`ifdef STALL_CTRL_MD_EN
    md_busy_cnt u_md_busy_cnt (
        .clk   (clk),
        .reset (reset),
        .start (e_q.md),
        .div   (e_q.div),
        .busy  (md_busy)
    );
    assign md_stall = d_md_use && md_busy;
`else
    logic unused_md_inputs;
    assign unused_md_inputs = ^{d_md_start, d_md_div, d_md_use};
    assign md_busy  = 1'b0;
    assign md_stall = 1'b0;
`endif

    assign stall = data_stall || md_stall;

    // E takes the D instruction or a bubble; M always takes the old E entry
    // with its remaining latency reduced by one stage, floored at zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            e_q <= BUBBLE;
            m_q <= BUBBLE;
        end else begin
            e_q <= stall ? BUBBLE : d_entry;
            m_q.dest <= e_q.dest;
            m_q.tnew <= (e_q.tnew == TNEW_0) ? TNEW_0 : (e_q.tnew - 2'd1);
            m_q.md   <= e_q.md;
            m_q.div  <= e_q.div;
        end
    end

    // The md bits only matter while the entry sits in E.
    logic unused_m_md;
    assign unused_m_md = ^{m_q.md, m_q.div};

    assign e_dest = e_q.dest;
    assign e_tnew = e_q.tnew;
    assign m_dest = m_q.dest;
    assign m_tnew = m_q.tnew;

endmodule

// File: tb/tb_stall_ctrl.sv
module tb_stall_ctrl;

`ifdef STALL_CTRL_MD_EN
    localparam bit MD_EN = 1'b1;
`else
    localparam bit MD_EN = 1'b0;
`endif

    localparam int K_NOP  = 0;
    localparam int K_R    = 1;
    localparam int K_I    = 2;
    localparam int K_LD   = 3;
    localparam int K_ST   = 4;
    localparam int K_BR   = 5;
    localparam int K_JAL  = 6;
    localparam int K_MULT = 7;
    localparam int K_DIV  = 8;
    localparam int K_MFLO = 9;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic       d_j = 0, d_r = 0, d_i = 0, d_ld = 0, d_st = 0, d_jal = 0;
    logic [4:0] d_rs = 0, d_rt = 0, d_rd = 0;
    logic       d_md_start = 0, d_md_div = 0, d_md_use = 0;
    logic       stall;
    logic [4:0] e_dest, m_dest;
    logic [1:0] e_tnew, m_tnew;
    logic       md_busy;

    int tests = 0;
    int fails = 0;

    stall_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .d_j        (d_j),
        .d_r        (d_r),
        .d_i        (d_i),
        .d_ld       (d_ld),
        .d_st       (d_st),
        .d_jal      (d_jal),
        .d_rs       (d_rs),
        .d_rt       (d_rt),
        .d_rd       (d_rd),
        .d_md_start (d_md_start),
        .d_md_div   (d_md_div),
        .d_md_use   (d_md_use),
        .stall      (stall),
        .e_dest     (e_dest),
        .m_dest     (m_dest),
        .e_tnew     (e_tnew),
        .m_tnew     (m_tnew),
        .md_busy    (md_busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Each in-flight producer is kept as (dest, absolute cycle at which its
    // result becomes forwardable); remaining latency is derived from time.
    int cyc     = 0;
    int e_dst_m = 0, e_avail = 0;
    int m_dst_m = 0, m_avail = 0;
    int md_free = 0;

    function automatic int rem(input int avail);
        return (avail > cyc) ? (avail - cyc) : 0;
    endfunction

    function automatic bit op_hit(input int dest, input int avail, input int r,
                                  input bit has, input int tuse);
        return has && (dest != 0) && (dest == r) && (rem(avail) > tuse);
    endfunction

    function automatic bit model_busy();
        return MD_EN && (cyc < md_free);
    endfunction

    function automatic bit model_stall();
        bit rs_has, rt_has, data;
        int rs_t, rt_t;
        rs_has = 0; rt_has = 0; rs_t = 0; rt_t = 0;
        if (d_j) begin
            rs_has = 1; rt_has = 1;
        end else begin
            if (d_r || d_i || d_ld || d_st) begin rs_has = 1; rs_t = 1; end
            if (d_r) begin rt_has = 1; rt_t = 1; end
            else if (d_st) begin rt_has = 1; rt_t = 2; end
        end
        data = op_hit(e_dst_m, e_avail, int'(d_rs), rs_has, rs_t) ||
               op_hit(e_dst_m, e_avail, int'(d_rt), rt_has, rt_t) ||
               op_hit(m_dst_m, m_avail, int'(d_rs), rs_has, rs_t) ||
               op_hit(m_dst_m, m_avail, int'(d_rt), rt_has, rt_t);
        return data || (d_md_use && model_busy());
    endfunction

    function automatic int d_dest_model();
        if (d_r || d_jal) return int'(d_rd);
        if (d_i || d_ld) return int'(d_rt);
        return 0;
    endfunction

    function automatic int d_tnew_model();
        if (d_ld) return 2;
        if (d_r || d_i) return 1;
        return 0;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            e_dst_m = 0; e_avail = cyc;
            m_dst_m = 0; m_avail = cyc;
            md_free = cyc;
        end else begin
            bit s;
            int nc;
            s  = model_stall();
            nc = cyc + 1;
            m_dst_m = e_dst_m;
            m_avail = e_avail;
            if (s) begin
                e_dst_m = 0;
                e_avail = nc;
            end else begin
                e_dst_m = d_dest_model();
                e_avail = nc + d_tnew_model();
                // Busy for the E cycle plus the full count.
                if (MD_EN && d_md_start)
                    md_free = nc + (d_md_div ? 10 : 5) + 1;
            end
            cyc = nc;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        chk("cyc_stall",   stall,   model_stall());
        chk("cyc_e_dest",  e_dest,  e_dst_m);
        chk("cyc_e_tnew",  e_tnew,  rem(e_avail));
        chk("cyc_m_dest",  m_dest,  m_dst_m);
        chk("cyc_m_tnew",  m_tnew,  rem(m_avail));
        chk("cyc_md_busy", md_busy, model_busy());
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input int kind, input int rs, input int rt, input int rd);
        d_j = 0; d_r = 0; d_i = 0; d_ld = 0; d_st = 0; d_jal = 0;
        d_md_start = 0; d_md_div = 0; d_md_use = 0;
        d_rs = 5'(rs); d_rt = 5'(rt); d_rd = 5'(rd);
        case (kind)
            K_R:    d_r = 1;
            K_I:    d_i = 1;
            K_LD:   d_ld = 1;
            K_ST:   d_st = 1;
            K_BR:   d_j = 1;
            K_JAL:  begin d_jal = 1; d_rd = 5'd31; end
            K_MULT: begin d_r = 1; d_rd = 0; d_md_start = 1; d_md_use = 1; end
            K_DIV:  begin d_r = 1; d_rd = 0; d_md_start = 1; d_md_div = 1; d_md_use = 1; end
            K_MFLO: begin d_r = 1; d_rs = 0; d_rt = 0; d_md_use = 1; end
            default: begin d_rs = 0; d_rt = 0; d_rd = 0; end
        endcase
    endtask

    task automatic flush();
        set_instr(K_NOP, 0, 0, 0);
        step();
        step();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int n;
        #2;
        chk("rst_stall",   stall,   0);
        chk("rst_e_dest",  e_dest,  0);
        chk("rst_m_dest",  m_dest,  0);
        chk("rst_e_tnew",  e_tnew,  0);
        chk("rst_m_tnew",  m_tnew,  0);
        chk("rst_md_busy", md_busy, 0);
        step();
        reset = 1;

        // load-use
        set_instr(K_LD, 1, 8, 0);
        #1 chk("lu_first_stall", stall, 0);
        step();
        set_instr(K_R, 8, 2, 3);
        #1 chk("lu_stall", stall, 1);
        chk("lu_e_dest", e_dest, 8);
        chk("lu_e_tnew", e_tnew, 2);
        step();
        chk("lu_after_stall", stall, 0);
        chk("lu_m_dest", m_dest, 8);
        chk("lu_m_tnew", m_tnew, 1);
        flush();

        // branch after ALU
        set_instr(K_R, 1, 2, 9);
        step();
        set_instr(K_BR, 1, 9, 0);
        #1 chk("br_stall", stall, 1);
        step();
        chk("br_after_stall", stall, 0);
        chk("br_m_tnew", m_tnew, 0);
        flush();

        // store data operand
        set_instr(K_LD, 0, 10, 0);
        step();
        set_instr(K_ST, 5, 10, 0);
        #1 chk("st_data_stall", stall, 0);
        set_instr(K_ST, 10, 3, 0);
        #1 chk("st_base_stall", stall, 1);
        flush();

        // $0 never stalls
        set_instr(K_R, 1, 2, 0);
        step();
        set_instr(K_BR, 0, 0, 0);
        #1 chk("zero_stall0", stall, 0);
        step();
        chk("zero_stall1", stall, 0);
        flush();

        // divide then mflo
        set_instr(K_DIV, 1, 2, 0);
        step();
        set_instr(K_MFLO, 0, 0, 7);
        #1;
`ifdef STALL_CTRL_MD_EN
        n = 0;
        while (stall && n < 30) begin
            n++;
            step();
        end
        chk("md_stall_cycles", n, 11);
        chk("md_busy_dropped", md_busy, 0);
`else
        chk("md_off_stall", stall, 0);
        chk("md_off_busy", md_busy, 0);
`endif
        flush();

        // reset in the middle of a divide
        set_instr(K_DIV, 1, 2, 0);
        step();
        set_instr(K_NOP, 0, 0, 0);
        for (int i = 0; i < 5; i++) step();
`ifdef STALL_CTRL_MD_EN
        chk("rmd_busy_before", md_busy, 1);
`endif
        reset = 0;
        #1 chk("rmd_busy_now", md_busy, 0);
        chk("rmd_e_dest", e_dest, 0);
        chk("rmd_stall", stall, 0);
        step();
        reset = 1;
        set_instr(K_MFLO, 0, 0, 4);
        #1 chk("rmd_mfhi_stall", stall, 0);
        step();
        chk("rmd_mfhi_e_dest", e_dest, 4);
        chk("rmd_mfhi_e_tnew", e_tnew, 1);

        // randomized traffic; held while the model says D is stalled
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 80) == 0) begin
                reset = 0;
                step();
                reset = 1;
            end else if (!model_stall()) begin
                set_instr($urandom_range(0, 9), $urandom_range(0, 4),
                          $urandom_range(0, 4), $urandom_range(0, 4));
            end
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
